dma_seq_ctrl: RTL and testbench

- Sequencer for the Am2940-style DMA generator.
- Accepts one transfer command, then drives the load/enable/direction inputs of two external counter instances: an address counter and a word counter.
- Hands out one bus-transfer request per word and advances the counters on each acknowledge.
- Terminates on word count exhaustion or abort.

---
 rtl/dma_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dma_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_seq_ctrl.sv
// ---------------------------------------------------------------------------
// dma_seq_ctrl
//
// Sequencer for an Am2940-style DMA generator. Takes one transfer command,
// loads an external address counter and an external word counter, then
// issues one bus-transfer request per word, stepping both counters on every
// acknowledge until the word count runs out or the transfer is aborted.
//
// Ports
//   clk, res                  clock (rising edge), async active-high reset
//   cmd_valid / cmd_ready     command handshake; accepted when both high
//   cmd_addr, cmd_count       start address, word count (0 = 2^CNT_W words)
//   cmd_mode                  bit0: 1 = address up; bit1: 1 = hold address
//   abort                     terminate the current transfer
//   addr_load/en/up, addr_data, addr_carry   address counter interface
//   wc_load/en/up, wc_data, wc_count         word counter interface
//   xfer_req / xfer_ack       bus transfer request / completion
//   busy, done, aborted, wrapped             status
// ---------------------------------------------------------------------------
module dma_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [1:0]       cmd_mode,
  input  logic             abort,
  output logic             addr_load,
  output logic             addr_en,
  output logic             addr_up,
  output logic [CNT_W-1:0] addr_data,
  input  logic             addr_carry,
  output logic             wc_load,
  output logic             wc_en,
  output logic             wc_up,
  output logic [CNT_W-1:0] wc_data,
  input  logic [CNT_W-1:0] wc_count,
  output logic             xfer_req,
  input  logic             xfer_ack,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrapped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_XFER,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       mode_q, mode_d;
  logic             wrapped_q, wrapped_d;
  logic             aborted_q, aborted_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             load_q, load_d;
  logic             done_q, done_d;

  logic             in_xfer;
  logic             abort_act;
  logic             ack_ok;
  logic             last_word;

  // Abort only matters while a transfer is being set up or running; in IDLE
  // there is nothing to stop and DONE always completes.
  assign in_xfer   = (state_q == S_XFER);
  assign abort_act = abort && ((state_q == S_LOAD) || (state_q == S_SETTLE) ||
                               in_xfer);
  // Abort wins over a coincident acknowledge: that word is not counted.
  assign ack_ok    = in_xfer && xfer_ack && !abort;

  // The word counter counts down and the last word is the one acknowledged
  // while it reads 1. A count of 0 loads 0, the first acknowledge steps it
  // through 0 to all-ones, and the same compare then ends the run after
  // 2^CNT_W words without any special case.
  assign last_word = (wc_count == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    mode_d    = mode_q;
    wrapped_d = wrapped_q;
    aborted_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          count_d   = cmd_count;
          mode_d    = cmd_mode;
          wrapped_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_XFER;
      S_XFER: begin
        if (xfer_ack && last_word) state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (abort_act) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end

    // The address counter rolls over on the same edge it is enabled at its
    // terminal value; that edge marks the transfer as wrapped.
    if (addr_en && addr_carry) wrapped_d = 1'b1;
  end

  // Status and load strobes are registered copies of the next-state decode,
  // so they line up exactly with the state they describe.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    load_d  = (state_d == S_LOAD);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      mode_q    <= '0;
      wrapped_q <= 1'b0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      wrapped_q <= wrapped_d;
      aborted_q <= aborted_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      load_q    <= load_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign wrapped   = wrapped_q;

  assign addr_load = load_q;
  assign addr_data = addr_q;
  // Direction only changes on command accept, so it is stable from LOAD on.
  assign addr_up   = mode_q[0];
  assign addr_en   = ack_ok && !mode_q[1];

  assign wc_load   = load_q;
  assign wc_data   = count_q;
  assign wc_up     = 1'b0;
  assign wc_en     = ack_ok;

  assign xfer_req  = in_xfer;

endmodule

// File: tb/tb_dma_seq_ctrl.sv
module tb_dma_seq_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             res;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_addr;
  logic [CNT_W-1:0] cmd_count;
  logic [1:0]       cmd_mode;
  logic             abort;
  logic             addr_load, addr_en, addr_up;
  logic [CNT_W-1:0] addr_data;
  logic             addr_carry;
  logic             wc_load, wc_en, wc_up;
  logic [CNT_W-1:0] wc_data;
  logic [CNT_W-1:0] wc_count;
  logic             xfer_req;
  logic             xfer_ack;
  logic             busy, done, aborted, wrapped;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dma_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .res(res),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_count(cmd_count), .cmd_mode(cmd_mode),
    .abort(abort),
    .addr_load(addr_load), .addr_en(addr_en), .addr_up(addr_up),
    .addr_data(addr_data), .addr_carry(addr_carry),
    .wc_load(wc_load), .wc_en(wc_en), .wc_up(wc_up),
    .wc_data(wc_data), .wc_count(wc_count),
    .xfer_req(xfer_req), .xfer_ack(xfer_ack),
    .busy(busy), .done(done), .aborted(aborted), .wrapped(wrapped)
  );

  // External Am2940-style counters: load has priority over enable.
  logic [CNT_W-1:0] addr_cnt = '0;
  logic [CNT_W-1:0] wc_cnt   = '0;

  always_ff @(posedge clk) begin
    if (addr_load)    addr_cnt <= addr_data;
    else if (addr_en) addr_cnt <= addr_up ? addr_cnt + 4'd1 : addr_cnt - 4'd1;
    if (wc_load)      wc_cnt <= wc_data;
    else if (wc_en)   wc_cnt <= wc_up ? wc_cnt + 4'd1 : wc_cnt - 4'd1;
  end

  assign addr_carry = addr_up ? (addr_cnt == 4'hF) : (addr_cnt == 4'h0);
  assign wc_count   = wc_cnt;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] count;
    logic [1:0] mode;
    int gap;         // idle XFER cycles before each ack
    int abort_ack;   // assert abort with this ack number (0 = never)
    int abort_cyc;   // assert abort in this cycle after accept (0 = never)
    int exp_acks;
    int exp_cycles;  // samples from accept until cmd_ready seen again
    int exp_done;
    int exp_aborted;
    int exp_wrapped;
  } vec_t;

  vec_t vecs[10];
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    for (n = 0; n < 20; n++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    if (n == 20) chk("ready_timeout", 0, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int acks, cyc, dones, aborts, loads, wait_c, ackn, en_err;
    logic hold, fin, go;
    logic [3:0] ea;
    acks = 0; dones = 0; aborts = 0; loads = 0; wait_c = 0; ackn = 0;
    en_err = 0; fin = 1'b0;
    hold = v.mode[1];

    wait_ready();
    exp_q.delete();
    ea = v.addr;
    for (int i = 0; i < v.exp_acks; i++) begin
      exp_q.push_back(ea);
      if (!hold) ea = v.mode[0] ? ea + 4'd1 : ea - 4'd1;
    end

    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_count = v.count;
    cmd_mode  = v.mode;
    @(negedge clk);
    // Keep offering a different command while busy; it must be ignored.
    cmd_addr  = ~v.addr;
    cmd_count = ~v.count;
    cmd_mode  = ~v.mode;

    for (cyc = 1; cyc <= 100; cyc++) begin
      xfer_ack = 1'b0;
      abort    = 1'b0;
      if (done)    dones++;
      if (aborted) aborts++;
      if (addr_load) begin
        loads++;
        if (addr_data !== v.addr || wc_data !== v.count || !wc_load) en_err++;
      end
      if (cmd_ready) begin
        fin = 1'b1;
        break;
      end
      if (xfer_req) begin
        if (addr_up !== v.mode[0]) en_err++;
        if (wait_c == v.gap) begin
          xfer_ack = 1'b1;
          wait_c   = 0;
          ackn++;
          if (ackn == v.abort_ack) abort = 1'b1;
        end else begin
          wait_c++;
        end
      end else begin
        xfer_ack = 1'b1;  // stray ack outside XFER must be ignored
      end
      if (cyc == v.abort_cyc) abort = 1'b1;
      #1;
      go = xfer_req & xfer_ack & ~abort;
      if (wc_en !== go) en_err++;
      if (addr_en !== (go & ~hold)) en_err++;
      if (go) begin
        acks++;
        if (exp_q.size() == 0) chk($sformatf("v%0d_extra_ack", idx), 1, 0);
        else chk($sformatf("v%0d_addr%0d", idx, acks), addr_cnt, exp_q.pop_front());
      end
      @(negedge clk);
    end

    cmd_valid = 1'b0;
    xfer_ack  = 1'b0;
    abort     = 1'b0;
    if (!fin) chk($sformatf("v%0d_timeout", idx), 0, 1);
    chk($sformatf("v%0d_acks", idx), acks, v.exp_acks);
    chk($sformatf("v%0d_cycles", idx), cyc, v.exp_cycles);
    chk($sformatf("v%0d_done", idx), dones, v.exp_done);
    chk($sformatf("v%0d_aborted", idx), aborts, v.exp_aborted);
    chk($sformatf("v%0d_wrapped", idx), wrapped, v.exp_wrapped);
    chk($sformatf("v%0d_loads", idx), loads, 1);
    chk($sformatf("v%0d_ctrl_err", idx), en_err, 0);
    chk($sformatf("v%0d_sb_left", idx), exp_q.size(), 0);
  endtask

  initial begin
    logic [3:0] sv_addr, sv_wc;
    // addr, count, mode, gap, abort_ack, abort_cyc, acks, cycles, done, aborted, wrapped
    vecs[0] = '{4'hA, 4'd3, 2'b01, 0, 0, 0,  3,  7, 1, 0, 0};
    vecs[1] = '{4'hD, 4'd5, 2'b01, 0, 0, 0,  5,  9, 1, 0, 1};
    vecs[2] = '{4'h2, 4'd0, 2'b00, 1, 0, 0, 16, 36, 1, 0, 1};
    vecs[3] = '{4'h7, 4'd4, 2'b10, 0, 0, 0,  4,  8, 1, 0, 0};
    vecs[4] = '{4'h3, 4'd6, 2'b01, 0, 2, 0,  1,  5, 0, 1, 0};
    vecs[5] = '{4'h0, 4'd1, 2'b00, 0, 0, 0,  1,  5, 1, 0, 1};
    vecs[6] = '{4'hF, 4'd2, 2'b11, 0, 0, 0,  2,  6, 1, 0, 0};
    vecs[7] = '{4'h9, 4'd3, 2'b01, 0, 0, 1,  0,  2, 0, 1, 0};
    vecs[8] = '{4'h5, 4'd1, 2'b01, 0, 0, 4,  1,  5, 1, 0, 0};
    vecs[9] = '{4'h4, 4'd2, 2'b00, 0, 0, 2,  0,  3, 0, 1, 0};

    res = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_count = '0;
    cmd_mode = '0; abort = 1'b0; xfer_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_status", {busy, done, aborted, wrapped, xfer_req}, 0);
    chk("rst_ctrl", {addr_load, addr_en, addr_up, wc_load, wc_en, wc_up}, 0);
    chk("rst_data", {addr_data, wc_data}, 0);
    res = 1'b0;
    @(negedge clk);
    xfer_ack = 1'b1;
    #1;
    chk("idle_ack_ignored", {wc_en, addr_en, busy}, 0);
    xfer_ack = 1'b0;

    // Reset asserted mid-XFER while an ack is being presented.
    cmd_valid = 1'b1; cmd_addr = 4'hA; cmd_count = 4'd5; cmd_mode = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_xfer_req", xfer_req, 1);
    xfer_ack = 1'b1;
    #1;
    chk("mid_wc_en", wc_en, 1);
    res = 1'b1;
    #1;
    chk("async_rst_drop", {xfer_req, busy, wc_en, addr_en}, 0);
    chk("async_rst_ready", cmd_ready, 1);
    xfer_ack = 1'b0;
    sv_addr = addr_cnt;
    sv_wc   = wc_cnt;
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_addr_cnt", addr_cnt, sv_addr);
    chk("post_rst_wc_cnt", wc_cnt, sv_wc);
    chk("post_rst_status", {done, aborted, wrapped, busy}, 0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
